// File: rtl/uart_verici_fifolu_pkg.sv
// Shared constants for the FIFO-buffered UART transmitter: parity codes,
// FSM state encoding and counter widths.
package uart_verici_fifolu_pkg;

  localparam logic [1:0] PAR_YOK  = 2'b00;
  localparam logic [1:0] PAR_CIFT = 2'b01;
  localparam logic [1:0] PAR_TEK  = 2'b10;

  localparam int unsigned BAUD_W    = 16;
  localparam int unsigned BIT_SAY_W = 4;

  typedef enum logic [2:0] {
    BOSTA  = 3'd0,
    BASLA  = 3'd1,
    VERI   = 3'd2,
    PARITE = 3'd3,
    DUR    = 3'd4
  } durum_e;

  // Code 11 is treated the same as "no parity".
  function automatic logic parite_aktif(input logic [1:0] mod);
    return (mod == PAR_CIFT) || (mod == PAR_TEK);
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with power-of-two depth; pointers wrap naturally and the
// word count distinguishes full from empty.
module uart_fifo #(
  parameter int unsigned GENISLIK = 8,
  parameter int unsigned DERINLIK = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        yaz_i,
  input  logic [GENISLIK-1:0]         yaz_veri_i,
  input  logic                        oku_i,
  output logic [GENISLIK-1:0]         oku_veri_c,
  output logic [$clog2(DERINLIK):0]   sayac_o,
  output logic                        dolu_c,
  output logic                        bos_c
);

  localparam int unsigned AW = $clog2(DERINLIK);
  localparam int unsigned CW = AW + 1;

  logic [GENISLIK-1:0] mem_q [DERINLIK];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       sayac_q, sayac_d;
  logic                yaz_ok, oku_ok;

  assign dolu_c     = (sayac_q == CW'(DERINLIK));
  assign bos_c      = (sayac_q == '0);
  assign yaz_ok     = yaz_i && !dolu_c;
  assign oku_ok     = oku_i && !bos_c;
  assign oku_veri_c = mem_q[rd_ptr_q];
  assign sayac_o    = sayac_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    sayac_d  = sayac_q;
    if (yaz_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (oku_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({yaz_ok, oku_ok})
      2'b10:   sayac_d = sayac_q + CW'(1);
      2'b01:   sayac_d = sayac_q - CW'(1);
      default: sayac_d = sayac_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      sayac_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      sayac_q  <= sayac_d;
    end
  end

  // Storage carries no reset; contents are unreachable until rewritten.
  always_ff @(posedge clk_i) begin
    if (yaz_ok) mem_q[wr_ptr_q] <= yaz_veri_i;
  end

endmodule

// File: rtl/uart_verici_fifolu.sv
// UART transmitter fed by a word FIFO; frame settings are captured when each
// frame starts so mid-frame configuration changes only affect later frames.
module uart_verici_fifolu
  import uart_verici_fifolu_pkg::*;
#(
  parameter int unsigned VERI_BIT      = 8,
  parameter int unsigned FIFO_DERINLIK = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [VERI_BIT-1:0]              veri_i,
  input  logic                             veri_gecerli_i,
  output logic                             veri_hazir_o,
  input  logic [15:0]                      baud_div_i,
  input  logic [1:0]                       parite_mod_i,
  input  logic                             dur_bit_i,
  output logic                             tx_o,
  output logic                             mesgul_o,
  output logic [$clog2(FIFO_DERINLIK):0]   doluluk_o
);

  localparam int unsigned DW = $clog2(FIFO_DERINLIK) + 1;

  durum_e                durum_q, durum_d;
  logic [BAUD_W-1:0]     baud_q, baud_d;
  logic [BAUD_W-1:0]     bolen_q, bolen_d;
  logic [BIT_SAY_W-1:0]  bit_q, bit_d;
  logic [VERI_BIT-1:0]   kay_q, kay_d;
  logic                  par_bit_q, par_bit_d;
  logic                  par_en_q, par_en_d;
  logic                  dur2_q, dur2_d;
  logic                  tx_q, tx_d;
  logic                  hazir_q, hazir_d;
  logic                  mesgul_q, mesgul_d;

  logic                  yaz_c, pop_c, basla_c, bit_son_c, bos_c, dolu_c;
  logic [VERI_BIT-1:0]   fifo_veri_c;
  logic [DW-1:0]         sayac;
  logic [DW-1:0]         sayac_sonraki_c;

  assign yaz_c     = veri_gecerli_i && hazir_q && !rst_i;
  assign bit_son_c = (baud_q == bolen_q - BAUD_W'(1));

  uart_fifo #(
    .GENISLIK (VERI_BIT),
    .DERINLIK (FIFO_DERINLIK)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .yaz_i      (yaz_c),
    .yaz_veri_i (veri_i),
    .oku_i      (pop_c),
    .oku_veri_c (fifo_veri_c),
    .sayac_o    (sayac),
    .dolu_c     (dolu_c),
    .bos_c      (bos_c)
  );

  // Next-state, bit timing and serial data selection.
  always_comb begin
    durum_d   = durum_q;
    baud_d    = baud_q;
    bolen_d   = bolen_q;
    bit_d     = bit_q;
    kay_d     = kay_q;
    par_bit_d = par_bit_q;
    par_en_d  = par_en_q;
    dur2_d    = dur2_q;
    tx_d      = tx_q;
    basla_c   = 1'b0;
    pop_c     = 1'b0;

    case (durum_q)
      BOSTA: begin
        tx_d = 1'b1;
        if (!bos_c) basla_c = 1'b1;
      end
      BASLA: begin
        if (bit_son_c) begin
          durum_d = VERI;
          tx_d    = kay_q[0];
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      VERI: begin
        if (bit_son_c) begin
          baud_d = '0;
          if (bit_q == BIT_SAY_W'(VERI_BIT - 1)) begin
            bit_d = '0;
            if (par_en_q) begin
              durum_d = PARITE;
              tx_d    = par_bit_q;
            end else begin
              durum_d = DUR;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + BIT_SAY_W'(1);
            kay_d = kay_q >> 1;
            tx_d  = kay_q[1];
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      PARITE: begin
        if (bit_son_c) begin
          durum_d = DUR;
          tx_d    = 1'b1;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DUR: begin
        if (bit_son_c) begin
          baud_d = '0;
          if (dur2_q && (bit_q == '0)) begin
            bit_d = BIT_SAY_W'(1);
          end else if (!bos_c) begin
            basla_c = 1'b1;
          end else begin
            durum_d = BOSTA;
            tx_d    = 1'b1;
            bit_d   = '0;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        durum_d = BOSTA;
        tx_d    = 1'b1;
      end
    endcase

    // Frame start: pop the word and freeze this frame's configuration.
    if (basla_c) begin
      pop_c     = 1'b1;
      durum_d   = BASLA;
      tx_d      = 1'b0;
      baud_d    = '0;
      bit_d     = '0;
      kay_d     = fifo_veri_c;
      par_bit_d = (^fifo_veri_c) ^ (parite_mod_i == PAR_TEK);
      par_en_d  = parite_aktif(parite_mod_i);
      dur2_d    = dur_bit_i;
      bolen_d   = (baud_div_i == 16'd0) ? BAUD_W'(1) : baud_div_i;
    end
  end

  // Occupancy after this edge drives the registered ready and busy flags.
  always_comb begin
    sayac_sonraki_c = sayac;
    case ({yaz_c && !dolu_c, pop_c && !bos_c})
      2'b10:   sayac_sonraki_c = sayac + DW'(1);
      2'b01:   sayac_sonraki_c = sayac - DW'(1);
      default: sayac_sonraki_c = sayac;
    endcase
    hazir_d  = (sayac_sonraki_c != DW'(FIFO_DERINLIK));
    mesgul_d = !((durum_d == BOSTA) && (sayac_sonraki_c == '0));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q   <= BOSTA;
      baud_q    <= '0;
      bolen_q   <= BAUD_W'(1);
      bit_q     <= '0;
      kay_q     <= '0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
      dur2_q    <= 1'b0;
      tx_q      <= 1'b1;
      hazir_q   <= 1'b1;
      mesgul_q  <= 1'b0;
    end else begin
      durum_q   <= durum_d;
      baud_q    <= baud_d;
      bolen_q   <= bolen_d;
      bit_q     <= bit_d;
      kay_q     <= kay_d;
      par_bit_q <= par_bit_d;
      par_en_q  <= par_en_d;
      dur2_q    <= dur2_d;
      tx_q      <= tx_d;
      hazir_q   <= hazir_d;
      mesgul_q  <= mesgul_d;
    end
  end

  assign tx_o         = tx_q;
  assign veri_hazir_o = hazir_q;
  assign mesgul_o     = mesgul_q;
  assign doluluk_o    = sayac;

endmodule

// File: tb/tb_uart_verici_fifolu.sv
// Directed bench for the FIFO-buffered UART transmitter (8 data bits, depth 4).
module tb_uart_verici_fifolu;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [7:0]  veri_i;
  logic        veri_gecerli_i;
  logic        veri_hazir_o;
  logic [15:0] baud_div_i;
  logic [1:0]  parite_mod_i;
  logic        dur_bit_i;
  logic        tx_o;
  logic        mesgul_o;
  logic [2:0]  doluluk_o;

  int n_chk  = 0;
  int n_fail = 0;

  logic cap_tx  [0:255];
  logic cap_mes [0:255];

  always #5 clk = ~clk;

  uart_verici_fifolu #(
    .VERI_BIT      (8),
    .FIFO_DERINLIK (4)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .veri_i         (veri_i),
    .veri_gecerli_i (veri_gecerli_i),
    .veri_hazir_o   (veri_hazir_o),
    .baud_div_i     (baud_div_i),
    .parite_mod_i   (parite_mod_i),
    .dur_bit_i      (dur_bit_i),
    .tx_o           (tx_o),
    .mesgul_o       (mesgul_o),
    .doluluk_o      (doluluk_o)
  );

  task automatic cap_run(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      @(negedge clk);
      cap_tx[i]  = tx_o;
      cap_mes[i] = mesgul_o;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (mesgul_o !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_chk++;
    if (mesgul_o !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_timeout: mesgul_o=%b required 0", mesgul_o);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; veri_gecerli_i = 1'b1; veri_i = 8'h3C;
    baud_div_i = 16'd4; parite_mod_i = 2'b00; dur_bit_i = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (tx_o !== 1'b1) begin n_fail++; $display("FAIL rst_tx: got %b want 1", tx_o); end
    n_chk++; if (veri_hazir_o !== 1'b1) begin n_fail++; $display("FAIL rst_hazir: got %b want 1", veri_hazir_o); end
    n_chk++; if (mesgul_o !== 1'b0) begin n_fail++; $display("FAIL rst_mesgul: got %b want 0", mesgul_o); end
    n_chk++; if (doluluk_o !== 3'd0) begin n_fail++; $display("FAIL rst_doluluk: got %0d want 0", doluluk_o); end
    rst_i = 1'b0; veri_gecerli_i = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (tx_o !== 1'b1 || mesgul_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_release_idle: tx=%b mesgul=%b want 1/0", tx_o, mesgul_o);
    end
  endtask

  task automatic test_frame_8n1();
    logic [7:0] w;
    logic       e;
    w = 8'hA5;
    baud_div_i = 16'd4; parite_mod_i = 2'b00; dur_bit_i = 1'b0;
    veri_i = w; veri_gecerli_i = 1'b1;
    @(negedge clk);
    veri_gecerli_i = 1'b0;
    n_chk++; if (tx_o !== 1'b1) begin n_fail++; $display("FAIL 8n1_write_edge_tx: got %b want 1", tx_o); end
    cap_run(0, 40);
    for (int b = 0; b < 10; b++) begin
      e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : w[b-1];
      for (int s = 0; s < 4; s++) begin
        n_chk++;
        if (cap_tx[b*4+s] !== e) begin
          n_fail++; $display("FAIL 8n1_bit%0d_clk%0d: tx=%b want %b", b, s, cap_tx[b*4+s], e);
        end
      end
    end
    n_chk++; if (cap_mes[39] !== 1'b1) begin n_fail++; $display("FAIL 8n1_busy_last_stop: got %b want 1", cap_mes[39]); end
    n_chk++; if (cap_mes[40] !== 1'b0 || cap_tx[40] !== 1'b1) begin
      n_fail++; $display("FAIL 8n1_idle_after: mesgul=%b tx=%b want 0/1", cap_mes[40], cap_tx[40]);
    end
    wait_idle();
  endtask

  task automatic test_parity();
    logic [1:0] mods [2];
    logic       pbit [2];
    mods[0] = 2'b01; pbit[0] = 1'b1;
    mods[1] = 2'b10; pbit[1] = 1'b0;
    for (int m = 0; m < 2; m++) begin
      baud_div_i = 16'd2; parite_mod_i = mods[m]; dur_bit_i = 1'b0;
      veri_i = 8'h07; veri_gecerli_i = 1'b1;
      @(negedge clk);
      veri_gecerli_i = 1'b0;
      cap_run(0, 22);
      n_chk++; if (cap_tx[16] !== 1'b0 || cap_tx[17] !== 1'b0) begin
        n_fail++; $display("FAIL par%0d_bit7: tx=%b%b want 00", m, cap_tx[16], cap_tx[17]);
      end
      n_chk++; if (cap_tx[18] !== pbit[m] || cap_tx[19] !== pbit[m]) begin
        n_fail++; $display("FAIL par%0d_parity: tx=%b%b want %b%b", m, cap_tx[18], cap_tx[19], pbit[m], pbit[m]);
      end
      n_chk++; if (cap_tx[20] !== 1'b1 || cap_tx[21] !== 1'b1 || cap_mes[21] !== 1'b1) begin
        n_fail++; $display("FAIL par%0d_stop: tx=%b%b mesgul=%b want 11/1", m, cap_tx[20], cap_tx[21], cap_mes[21]);
      end
      n_chk++; if (cap_mes[22] !== 1'b0) begin
        n_fail++; $display("FAIL par%0d_len11: mesgul=%b want 0", m, cap_mes[22]);
      end
      wait_idle();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w [6];
    logic [2:0] e_dol [6];
    logic       e_hz  [6];
    logic       e;
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h3C; w[3] = 8'h81; w[4] = 8'hF0; w[5] = 8'h5A;
    e_dol[0] = 3'd1; e_dol[1] = 3'd1; e_dol[2] = 3'd2; e_dol[3] = 3'd3; e_dol[4] = 3'd4; e_dol[5] = 3'd4;
    e_hz[0] = 1'b1; e_hz[1] = 1'b1; e_hz[2] = 1'b1; e_hz[3] = 1'b1; e_hz[4] = 1'b0; e_hz[5] = 1'b0;
    baud_div_i = 16'd2; parite_mod_i = 2'b00; dur_bit_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      veri_i = w[k]; veri_gecerli_i = 1'b1;
      @(negedge clk);
      if (k >= 1) begin cap_tx[k-1] = tx_o; cap_mes[k-1] = mesgul_o; end
      n_chk++; if (doluluk_o !== e_dol[k] || veri_hazir_o !== e_hz[k]) begin
        n_fail++; $display("FAIL b2b_write%0d: doluluk=%0d hazir=%b want %0d/%b", k, doluluk_o, veri_hazir_o, e_dol[k], e_hz[k]);
      end
    end
    veri_gecerli_i = 1'b0;
    cap_run(5, 109);
    for (int f = 0; f < 5; f++) begin
      for (int b = 0; b < 10; b++) begin
        e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : w[f][b-1];
        n_chk++;
        if (cap_tx[f*20+b*2] !== e || cap_tx[f*20+b*2+1] !== e) begin
          n_fail++; $display("FAIL b2b_frame%0d_bit%0d: tx=%b%b want %b", f, b, cap_tx[f*20+b*2], cap_tx[f*20+b*2+1], e);
        end
      end
    end
    for (int i = 100; i < 110; i++) begin
      n_chk++;
      if (cap_tx[i] !== 1'b1 || cap_mes[i] !== 1'b0) begin
        n_fail++; $display("FAIL b2b_refused_not_sent%0d: tx=%b mesgul=%b want 1/0", i, cap_tx[i], cap_mes[i]);
      end
    end
    wait_idle();
  endtask

  task automatic test_two_stop();
    baud_div_i = 16'd3; parite_mod_i = 2'b00; dur_bit_i = 1'b1;
    veri_i = 8'h55; veri_gecerli_i = 1'b1;
    @(negedge clk);
    veri_i = 8'hAA;
    @(negedge clk);
    veri_gecerli_i = 1'b0;
    cap_tx[0] = tx_o; cap_mes[0] = mesgul_o;
    cap_run(1, 66);
    n_chk++; if (cap_tx[26] !== 1'b0) begin n_fail++; $display("FAIL stop2_last_data: tx=%b want 0", cap_tx[26]); end
    for (int i = 27; i <= 32; i++) begin
      n_chk++; if (cap_tx[i] !== 1'b1) begin n_fail++; $display("FAIL stop2_high%0d: tx=%b want 1", i, cap_tx[i]); end
    end
    n_chk++; if (cap_tx[33] !== 1'b0) begin n_fail++; $display("FAIL stop2_next_start: tx=%b want 0", cap_tx[33]); end
    n_chk++; if (cap_tx[36] !== 1'b0 || cap_tx[39] !== 1'b1) begin
      n_fail++; $display("FAIL stop2_frame2_data: tx=%b,%b want 0,1", cap_tx[36], cap_tx[39]);
    end
    n_chk++; if (cap_mes[65] !== 1'b1 || cap_mes[66] !== 1'b0) begin
      n_fail++; $display("FAIL stop2_end: mesgul=%b%b want 10", cap_mes[65], cap_mes[66]);
    end
    dur_bit_i = 1'b0;
    wait_idle();
  endtask

  task automatic test_baud_zero();
    logic e;
    baud_div_i = 16'd0; parite_mod_i = 2'b00; dur_bit_i = 1'b0;
    veri_i = 8'h01; veri_gecerli_i = 1'b1;
    @(negedge clk);
    veri_gecerli_i = 1'b0;
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      cap_tx[i] = tx_o; cap_mes[i] = mesgul_o;
      if (i == 2) baud_div_i = 16'd5;
    end
    for (int i = 0; i <= 10; i++) begin
      e = (i == 1 || i >= 9) ? 1'b1 : 1'b0;
      n_chk++; if (cap_tx[i] !== e) begin n_fail++; $display("FAIL baud0_clk%0d: tx=%b want %b", i, cap_tx[i], e); end
    end
    n_chk++; if (cap_mes[9] !== 1'b1 || cap_mes[10] !== 1'b0) begin
      n_fail++; $display("FAIL baud0_len: mesgul=%b%b want 10", cap_mes[9], cap_mes[10]);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    logic [7:0] w [3];
    w[0] = 8'h00; w[1] = 8'hFF; w[2] = 8'hFF;
    baud_div_i = 16'd2; parite_mod_i = 2'b00; dur_bit_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      veri_i = w[k]; veri_gecerli_i = 1'b1;
      @(negedge clk);
      if (k >= 1) begin cap_tx[k-1] = tx_o; cap_mes[k-1] = mesgul_o; end
    end
    veri_gecerli_i = 1'b0;
    cap_run(2, 8);
    n_chk++; if (cap_tx[8] !== 1'b0 || doluluk_o !== 3'd2) begin
      n_fail++; $display("FAIL rmid_before: tx=%b doluluk=%0d want 0/2", cap_tx[8], doluluk_o);
    end
    rst_i = 1'b1; veri_i = 8'h33; veri_gecerli_i = 1'b1;
    @(negedge clk);
    n_chk++; if (tx_o !== 1'b1) begin n_fail++; $display("FAIL rmid_tx: got %b want 1", tx_o); end
    n_chk++; if (doluluk_o !== 3'd0) begin n_fail++; $display("FAIL rmid_doluluk: got %0d want 0", doluluk_o); end
    n_chk++; if (mesgul_o !== 1'b0 || veri_hazir_o !== 1'b1) begin
      n_fail++; $display("FAIL rmid_flags: mesgul=%b hazir=%b want 0/1", mesgul_o, veri_hazir_o);
    end
    rst_i = 1'b0; veri_gecerli_i = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_chk++;
      if (tx_o !== 1'b1 || mesgul_o !== 1'b0) begin
        n_fail++; $display("FAIL rmid_no_start%0d: tx=%b mesgul=%b want 1/0", i, tx_o, mesgul_o);
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; veri_i = '0; veri_gecerli_i = 1'b0;
    baud_div_i = 16'd4; parite_mod_i = 2'b00; dur_bit_i = 1'b0;
    @(negedge clk);
    test_reset();
    test_frame_8n1();
    test_parity();
    test_back_to_back();
    test_two_stop();
    test_baud_zero();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
